// File: rtl/a2d_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_arb_pkg
//  Description : Shared types and constants for the A2D converter arbiter.
//                Holds the arbiter state encoding, the A2D result and channel
//                widths, and a helper that sizes requester index fields.
//  Revision    : 1.0  initial release
// ============================================================================
package a2d_arb_pkg;

    localparam int A2D_RES_W   = 12;
    localparam int A2D_CHNNL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : a2d_arb_pkg
`default_nettype wire

// File: rtl/a2d_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Purely combinational round-robin picker. Returns the first
//                set bit of i_eff_req searching upward from i_ptr+1 with
//                wrap-around, plus a flag saying any request is present.
//  Ports       : i_eff_req  [NUM_REQ-1:0]  candidate request vector
//                i_ptr      [IDX_W-1:0]    index of the most recent winner
//                o_winner   [IDX_W-1:0]    selected index (0 when none)
//                o_any_req                 at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import a2d_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eff_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any_req
);

    logic w_found;

    // Two ordered passes: requesters above the pointer first, then the ones
    // at or below it. The first hit in scan order is the round-robin winner.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_eff_req[i] && (i > int'(i_ptr))) begin
                w_found  = 1'b1;
                o_winner = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_eff_req[i] && (i <= int'(i_ptr))) begin
                w_found  = 1'b1;
                o_winner = IDX_W'(i);
            end
        end
        o_any_req = |i_eff_req;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/a2d_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_arbiter
//  Description : Shares one A2D_intf SPI converter between NUM_REQ clients.
//                Level requests (each with a 3-bit channel) are granted in
//                round-robin order; each grant issues a one-cycle strt_cnv,
//                waits for cnv_cmplt and returns the result with a one-cycle
//                done strobe to the owner.
//  Ports       : clk, rst_n (async, active-low)
//                req[NUM_REQ-1:0], req_chnnl[3*NUM_REQ-1:0]  client side
//                done[NUM_REQ-1:0], res[11:0], err, busy     client side
//                strt_cnv, chnnl[2:0], cnv_cmplt, a2d_res    A2D_intf side
//  Options     : A2D_TIMEOUT_EN - when defined, a WAIT-state watchdog ends a
//                conversion after TIMEOUT_CYC cycles with done and err high.
//                When undefined err is tied low and WAIT has no limit.
//  Revision    : 1.0  initial release
// ============================================================================
module a2d_arbiter
    import a2d_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [A2D_CHNNL_W*NUM_REQ-1:0] req_chnnl,
    output logic [NUM_REQ-1:0]             done,
    output logic [A2D_RES_W-1:0]           res,
    output logic                           err,
    output logic                           busy,
    output logic                           strt_cnv,
    output logic [A2D_CHNNL_W-1:0]         chnnl,
    input  logic                           cnv_cmplt,
    input  logic [A2D_RES_W-1:0]           a2d_res
);

    localparam int                 c_IDX_W   = idx_width(NUM_REQ);
    // Pointer starts at the last client so client 0 wins the first grant.
    localparam logic [c_IDX_W-1:0] c_PTR_RST = c_IDX_W'(NUM_REQ - 1);

    arb_state_t               r_state;
    arb_state_t               w_state_nxt;
    logic [c_IDX_W-1:0]       r_owner;
    logic [c_IDX_W-1:0]       r_ptr;
    logic [A2D_CHNNL_W-1:0]   r_chnnl;
    logic [A2D_RES_W-1:0]     r_res;
    logic [NUM_REQ-1:0]       r_done;

    logic [NUM_REQ-1:0]       w_eff_req;
    logic [c_IDX_W-1:0]       w_winner;
    logic                     w_any_req;
    logic [A2D_CHNNL_W-1:0]   w_sel_chnnl;
    logic [NUM_REQ-1:0]       w_owner_onehot;
    logic                     w_grant;
    logic                     w_finish;
    logic                     w_timeout;

    // The client being released this cycle is masked, so a client that holds
    // req through its done cannot be re-granted back-to-back.
    assign w_eff_req = req & ~r_done;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .i_eff_req (w_eff_req),
        .i_ptr     (r_ptr),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    // Channel of the winning client and one-hot decode of the current owner.
    always_comb begin
        w_sel_chnnl    = '0;
        w_owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == c_IDX_W'(i)) begin
                w_sel_chnnl = req_chnnl[A2D_CHNNL_W*i +: A2D_CHNNL_W];
            end
            w_owner_onehot[i] = (r_owner == c_IDX_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_finish    = 1'b0;
        strt_cnv    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                strt_cnv    = 1'b1;
                busy        = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (cnv_cmplt || w_timeout) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant / completion datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= '0;
            r_ptr   <= c_PTR_RST;
            r_chnnl <= '0;
            r_res   <= '0;
            r_done  <= '0;
        end else begin
            r_done <= w_finish ? w_owner_onehot : '0;
            if (w_grant) begin
                r_owner <= w_winner;
                r_chnnl <= w_sel_chnnl;
            end
            if (w_finish) begin
                r_ptr <= r_owner;
                // A timed-out conversion leaves the previous result in place.
                if (cnv_cmplt) begin
                    r_res <= a2d_res;
                end
            end
        end
    end

`ifdef A2D_TIMEOUT_EN
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_wait_cnt;
    logic        r_err;

    // Counter is cleared while in START so it reads 0 on the first WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == START) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            // A real completion in the timeout cycle takes precedence.
            r_err <= w_finish & ~cnv_cmplt;
        end
    end

    assign w_timeout = (r_state == WAIT) && (r_wait_cnt == c_TO_LAST);
    assign err       = r_err;
`else
    logic [15:0] w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = 16'(TIMEOUT_CYC);
    assign w_timeout            = 1'b0;
    assign err                  = 1'b0;
`endif

    assign done  = r_done;
    assign res   = r_res;
    assign chnnl = r_chnnl;

endmodule : a2d_arbiter
`default_nettype wire

// File: tb/tb_a2d_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_a2d_arbiter
//  Description : Self-checking bench for a2d_arbiter. Directed vector table,
//                hand-written multi-cycle sequences (contention, held single
//                client, drop mid-conversion, reset in WAIT, optional
//                timeout) and a randomized phase against a transaction-level
//                reference model. Includes a behavioural A2D_intf model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_a2d_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int TIMEOUT_CYC = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [8:0]  req_chnnl = '0;
    logic [2:0]  done;
    logic [11:0] res;
    logic        err;
    logic        busy;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] a2d_res;

    int checks = 0;
    int errors = 0;

    a2d_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_chnnl (req_chnnl),
        .done      (done),
        .res       (res),
        .err       (err),
        .busy      (busy),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .a2d_res   (a2d_res)
    );

    always #5 clk = ~clk;

    // ---------------- A2D_intf behavioural model ----------------
    int         a2d_delay = 40;   // 0 selects a random 1..6 cycle delay
    bit         a2d_never = 1'b0;
    bit         a2d_spur  = 1'b0; // random stray cnv_cmplt while idle
    int         a2d_cnt   = 0;
    logic [2:0] a2d_ch    = '0;

    initial begin
        cnv_cmplt = 1'b0;
        a2d_res   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a2d_cnt = 0;
            end else if (strt_cnv) begin
                a2d_cnt = (a2d_delay == 0) ? int'($urandom_range(1, 6)) : a2d_delay;
                a2d_ch  = chnnl;
            end
            @(posedge clk);
            #1;
            cnv_cmplt = 1'b0;
            if (a2d_cnt > 0 && !a2d_never) begin
                a2d_cnt--;
                if (a2d_cnt == 0) begin
                    cnv_cmplt = 1'b1;
                    a2d_res   = 12'h100 + {9'd0, a2d_ch};
                end
            end else if (a2d_cnt == 0 && a2d_spur && $urandom_range(0, 3) == 0) begin
                cnv_cmplt = 1'b1;
                a2d_res   = 12'($urandom);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        req       = '0;
        req_chnnl = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Each wait advances at least one cycle, sampling on the falling edge.
    task automatic wait_strt(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!strt_cnv && n < max);
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == '0 && n < max);
    endtask

    // ---------------- transaction-level reference model ----------------
    bit         m_active;   // a conversion is granted and not yet finished
    int         m_age;      // cycles since the grant took effect
    int         m_owner;
    int         m_last;     // most recently served client
    logic [2:0] m_done;
    logic [11:0] m_res;
    logic       m_err;
    logic [2:0] m_chnnl;

    task automatic model_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_owner  = 0;
        m_last   = NUM_REQ - 1;
        m_done   = '0;
        m_res    = '0;
        m_err    = 1'b0;
        m_chnnl  = '0;
    endtask

    // Called at every rising edge with the inputs present at that edge.
    task automatic model_step();
        logic [2:0] nd;
        logic       ne;
        logic [2:0] elig;
        bit         to;
        nd = '0;
        ne = 1'b0;
        to = 1'b0;
        if (!m_active) begin
            elig = req & ~m_done;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (m_last + k) % NUM_REQ;
                if (!m_active && elig[c]) begin
                    m_active = 1'b1;
                    m_owner  = c;
                    m_age    = 0;
                    m_chnnl  = req_chnnl[3*c +: 3];
                end
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
`ifdef A2D_TIMEOUT_EN
            to = (m_age == TIMEOUT_CYC);
`endif
            if (cnv_cmplt || to) begin
                nd[m_owner] = 1'b1;
                ne          = !cnv_cmplt;
                if (cnv_cmplt) m_res = a2d_res;
                m_last   = m_owner;
                m_active = 1'b0;
            end else begin
                m_age++;
            end
        end
        m_done = nd;
        m_err  = ne;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  req;
        logic [8:0]  ch;
        logic [2:0]  exp_done;
        logic [11:0] exp_res;
        logic [2:0]  exp_ch;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();

        // Pointer sequence after reset: 2 -> 1 -> 0 -> 2 -> 0 -> 1 -> 2
        tbl[0] = '{3'b010, {3'd0, 3'd5, 3'd0}, 3'b010, 12'h105, 3'd5};
        tbl[1] = '{3'b001, {3'd0, 3'd0, 3'd7}, 3'b001, 12'h107, 3'd7};
        tbl[2] = '{3'b100, {3'd0, 3'd6, 3'd1}, 3'b100, 12'h100, 3'd0};
        tbl[3] = '{3'b011, {3'd0, 3'd3, 3'd1}, 3'b001, 12'h101, 3'd1};
        tbl[4] = '{3'b110, {3'd7, 3'd2, 3'd0}, 3'b010, 12'h102, 3'd2};
        tbl[5] = '{3'b101, {3'd4, 3'd0, 3'd3}, 3'b100, 12'h104, 3'd4};

        do_reset();
        @(negedge clk);
        check("reset_outputs", {done, res, err, busy, strt_cnv, chnnl}, '0);

        // ---- table-driven single transactions ----
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            req       = tbl[i].req;
            req_chnnl = tbl[i].ch;
            @(negedge clk);
            check("vec_no_strt_c0", strt_cnv, 1'b0);
            @(negedge clk);
            check("vec_strt_c1", strt_cnv, 1'b1);
            check("vec_chnnl", chnnl, tbl[i].exp_ch);
            check("vec_busy", busy, 1'b1);
            req_chnnl = 9'($urandom);
            wait_done(100, n);
            check("vec_latency", n, 41);
            check("vec_done", done, tbl[i].exp_done);
            check("vec_res", res, tbl[i].exp_res);
            check("vec_chnnl_held", chnnl, tbl[i].exp_ch);
            req = '0;
            @(negedge clk);
            check("vec_done_1cyc", done, 3'b000);
            check("vec_busy_low", busy, 1'b0);
        end

        // ---- contention: continuous requesters, order 0,1,2,0 ----
        do_reset();
        @(posedge clk);
        #1;
        req       = 3'b111;
        req_chnnl = {3'd6, 3'd4, 3'd2};
        for (int k = 0; k < 4; k++) begin
            logic [2:0] exp_d;
            exp_d = 3'b001 << (k % 3);
            wait_done(100, n);
            check("cont_done", done, exp_d);
            check("cont_res", res, 12'h102 + 12'(2 * (k % 3)));
        end
        req = '0;

        // ---- single client held: IDLE gap, no double start ----
        do_reset();
        @(posedge clk);
        #1;
        req       = 3'b001;
        req_chnnl = {3'd0, 3'd0, 3'd1};
        wait_strt(10, n);
        check("hold_strt1", strt_cnv, 1'b1);
        wait_done(100, n);
        check("hold_done1", done, 3'b001);
        @(negedge clk);
        check("hold_idle_gap", {busy, strt_cnv}, 2'b00);
        wait_strt(10, n);
        check("hold_restart_delay", n, 1);
        @(negedge clk);
        check("hold_no_double", strt_cnv, 1'b0);

        // ---- requester drops req mid-conversion ----
        do_reset();
        @(posedge clk);
        #1;
        req       = 3'b100;
        req_chnnl = {3'd3, 3'd0, 3'd5};
        wait_strt(10, n);
        check("drop_chnnl", chnnl, 3'd3);
        repeat (10) @(negedge clk);
        req = 3'b001;
        wait_done(100, n);
        check("drop_done", done, 3'b100);
        check("drop_res", res, 12'h103);
        wait_strt(10, n);
        check("drop_next_chnnl", chnnl, 3'd5);
        wait_done(100, n);
        check("drop_next_done", done, 3'b001);
        check("drop_next_res", res, 12'h105);
        req = '0;
        @(negedge clk);

        // ---- reset in WAIT ----
        @(posedge clk);
        #1;
        req       = 3'b010;
        req_chnnl = {3'd0, 3'd2, 3'd0};
        wait_strt(10, n);
        check("rstw_chnnl", chnnl, 3'd2);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_outputs", {done, res, err, busy, strt_cnv, chnnl}, '0);
        req       = 3'b111;
        req_chnnl = {3'd6, 3'd4, 3'd2};
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_strt(10, n);
        check("rstw_first_chnnl", chnnl, 3'd2);
        wait_done(100, n);
        check("rstw_first_done", done, 3'b001);
        check("rstw_first_res", res, 12'h102);
        req = '0;
        @(negedge clk);

`ifdef A2D_TIMEOUT_EN
        // ---- conversion never completes ----
        a2d_never = 1'b1;
        @(posedge clk);
        #1;
        req       = 3'b011;
        req_chnnl = {3'd0, 3'd3, 3'd1};
        wait_strt(10, n);
        check("to_chnnl", chnnl, 3'd3);
        wait_done(200, n);
        check("to_latency", n, TIMEOUT_CYC + 1);
        check("to_done", done, 3'b010);
        check("to_err", err, 1'b1);
        check("to_res_kept", res, 12'h102);
        @(negedge clk);
        check("to_err_1cyc", err, 1'b0);
        wait_strt(10, n);
        check("to_next_chnnl", chnnl, 3'd1);
        req       = '0;
        a2d_never = 1'b0;
`endif

        // ---- randomized phase against the reference model ----
        a2d_delay = 0;
        a2d_spur  = 1'b1;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [20:0] exp_v;
            @(posedge clk);
            model_step();
            #1;
            req       = 3'($urandom);
            req_chnnl = 9'($urandom);
            @(negedge clk);
            exp_v = {m_done, m_res, m_err, m_active, (m_active && m_age == 0), m_chnnl};
            check("rand_outputs", {done, res, err, busy, strt_cnv, chnnl}, 32'(exp_v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_a2d_arbiter
`default_nettype wire

// File: doc/a2d_arbiter.md
Name: a2d_arbiter

Overview:
Shares the single A2D_intf SPI converter between several requesters: the IR sensor sequencer, the battery monitor and the spare/diagnostic port. It accepts level requests that each carry a 3-bit channel, and grants them in round-robin order. For each grant it pulses strt_cnv and returns the 12-bit result to the owner with a one-cycle done strobe. It sits between the client blocks and the A2D_intf instance, and owns that instance's strt_cnv, chnnl, cnv_cmplt and res.

Parameters:
NUM_REQ, 3, number of requesters (1..8).
TIMEOUT_CYC, 4096, WAIT-state cycle limit; used only when A2D_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  level request per client; held until that client's done
req_chnnl  input  3*NUM_REQ  channel per client; slice i = [3*i+2:3*i]
done  output  NUM_REQ  one-cycle pulse to the owner; res valid in that cycle
res  output  12  last conversion result; held until the next completion
err  output  1  high with done when the conversion timed out (tied 0 without the macro)
busy  output  1  high in START and WAIT
strt_cnv  output  1  one-cycle start pulse to A2D_intf
chnnl  output  3  channel to A2D_intf; stable from START until the next grant
cnv_cmplt  input  1  completion pulse from A2D_intf
a2d_res  input  12  result from A2D_intf

Behaviour:
- Reset values: done=0, res=0, err=0, busy=0, strt_cnv=0, chnnl=0, owner=0, RR pointer=NUM_REQ-1 (so client 0 wins first), state=IDLE. Clock: clk. Reset: rst_n, asynchronous, active-low.
- States:
  - IDLE -> START when eff_req != 0.
  - START -> WAIT, unconditionally.
  - WAIT -> IDLE on cnv_cmplt (or on timeout).
- eff_req = req & ~done_q. The owner being released is masked in the cycle its done is high, so it can never be re-granted in that same cycle.
- IDLE grant:
  - winner = first set bit of eff_req searching from ptr+1 upward, with wrap-around.
  - Register owner<=winner and chnnl<=req_chnnl[winner] on the transition edge.
- START: strt_cnv=1 for exactly this one cycle; chnnl is already stable.
- WAIT: on the cnv_cmplt cycle, register res<=a2d_res, done[owner]<=1 and ptr<=owner, then go to IDLE.
  - done is high for one cycle, the cycle after cnv_cmplt.
- Latency: req rising in IDLE at cycle 0 -> strt_cnv at cycle 1 -> done at cycle Tc+2, where cnv_cmplt arrives at cycle Tc+1.
- With several continuous requesters, the grant order is 0,1,2,0,1,2... A request is never starved beyond NUM_REQ-1 intervening grants.
- Requester drops req while in START or WAIT:
  - The conversion still completes and done still pulses.
  - res is updated; the client ignores it.
- req_chnnl changing after the grant has no effect until the next grant.
- cnv_cmplt in IDLE or START is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A2D_intf shares rst_n and aborts together with the arbiter.
- NUM_REQ=1: the RR degenerates to a single client; the done-cycle mask forces at least one IDLE cycle between that client's grants.

Optional Feature:
A2D_TIMEOUT_EN
- Defined: a 16-bit counter clears on entering WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYC-1 without cnv_cmplt:
  - done[owner]=1 and err=1 for one cycle;
  - res is left unchanged;
  - ptr advances and the state returns to IDLE.
  - If cnv_cmplt and timeout coincide, cnv_cmplt wins (err=0).
- Undefined: no counter; err is tied 0; WAIT waits indefinitely.

Decomposition:
- Package a2d_arb_pkg holds:
  - enum arb_state_t {IDLE, START, WAIT}, 2-bit;
  - localparams A2D_RES_W=12 and A2D_CHNNL_W=3.
- Sub-module rr_pick, purely combinational:
  - inputs: eff_req[NUM_REQ-1:0], ptr;
  - outputs: winner index and any_req.
  - It is reused later by the motor-command scheduler.

Test Plan:
Each scenario uses an A2D model that returns 12'h100+chnnl, 40 cycles after strt_cnv.
- Single client: req[1]=1, req_chnnl slice1=3'd5. Expect strt_cnv one cycle later with chnnl=5, then done=3'b010 with res=12'h105, busy low after done.
- Contention: req=3'b111 held, with channels 2, 4, 6. Expect grant order 0,1,2,0, results 102, 104, 106, 102, exactly one done bit per completion.
- Single-client hold: req[0] held high continuously. Expect at least one IDLE cycle between done and the next strt_cnv, and no double strt_cnv.
- Drop mid-conversion: req[2] deasserted 10 cycles after strt_cnv. Expect done[2] still pulses, res updated, then the next requester is served.
- Reset in WAIT: assert rst_n=0 20 cycles after strt_cnv. Expect all outputs 0, state IDLE, and client 0 granted first after release.
- A2D_TIMEOUT_EN with TIMEOUT_CYC=64 and a model that never completes: done[owner]=1 and err=1 exactly 64 WAIT cycles after START, res unchanged, next requester granted.
